// File: rtl/fadd32_pkg.sv
// fadd32_pkg: shared types and constants for the fadd32 core and the
// fadd32_accum streaming accumulator.
//   state_t      : accumulator FSM states (IDLE / ACCUM / DONE)
//   FP_POS_ZERO  : binary32 +0.0, the value a fresh job starts from
//   FP_QNAN      : canonical quiet NaN produced by the fadd32 core
//   MODE_ADD/SUB : fadd32 mode select (b is negated for MODE_SUB)
package fadd32_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;
  localparam logic        MODE_ADD    = 1'b0;
  localparam logic        MODE_SUB    = 1'b1;

endpackage

// File: rtl/fadd32_accum_if.sv
// fadd32_accum_if: job/operand/result bundle of the accumulator.
// Handshake rule for both streams: a transfer happens on a rising clk edge
// where valid && ready are both high; the producer holds valid and payload
// stable until that edge, and ready never depends on valid combinationally.
//   start, len          : job request (sampled only while IDLE)
//   in_valid/in_ready   : operand stream, payload in_data/in_mode
//   out_valid/out_ready : result stream, payload out_data
//   busy                : job in progress (ACCUM or DONE)
//   dbg_state           : current FSM state, for observation only
// master = job/operand producer and result consumer; slave = accumulator.
interface fadd32_accum_if #(parameter int LEN_W = 8);
  import fadd32_pkg::*;

  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             busy;
  state_t           dbg_state;

  modport master (
    output start, len, in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, busy, dbg_state
  );

  modport slave (
    input  start, len, in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, busy, dbg_state
  );

endinterface

// File: rtl/fadd32.sv
// fadd32: combinational IEEE-754 binary32 adder/subtractor,
// round-to-nearest-even, with subnormal inputs and outputs.
//   a_i    : first operand
//   b_i    : second operand
//   mode_i : MODE_ADD -> a+b, MODE_SUB -> a-b
//   y_o    : result; any NaN input or inf-inf gives FP_QNAN
// Datapath: order by magnitude, align the smaller operand into a 27-bit
// field (24 mantissa + guard, round, sticky), add/subtract, normalise,
// then round by adding one to the packed {exponent, fraction} so that a
// mantissa carry bumps the exponent (and reaches infinity) for free.
module fadd32
  import fadd32_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        mode_i,
  output logic [31:0] y_o
);

  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic        swap;
  logic        sx, sy;
  logic [7:0]  ex, ey;
  logic [23:0] mx, my;
  logic [7:0]  d;
  logic [49:0] sh_y;
  logic [26:0] al_y;
  logic [27:0] s;
  logic [4:0]  lz;
  logic [7:0]  nsh;
  logic [8:0]  en;
  logic [26:0] n;
  logic        rnd;
  logic [30:0] pk;

  always_comb begin
    sa    = a_i[31];
    sb    = b_i[31] ^ (mode_i != MODE_ADD);
    ea    = a_i[30:23];
    eb    = b_i[30:23];
    a_nan = (ea == 8'hFF) && (a_i[22:0] != 23'd0);
    b_nan = (eb == 8'hFF) && (b_i[22:0] != 23'd0);
    a_inf = (ea == 8'hFF) && (a_i[22:0] == 23'd0);
    b_inf = (eb == 8'hFF) && (b_i[22:0] == 23'd0);

    // x is the larger magnitude; subnormals use effective exponent 1
    swap = b_i[30:0] > a_i[30:0];
    if (swap) begin
      sx = sb; ex = (eb == 8'd0) ? 8'd1 : eb; mx = {eb != 8'd0, b_i[22:0]};
      sy = sa; ey = (ea == 8'd0) ? 8'd1 : ea; my = {ea != 8'd0, a_i[22:0]};
    end else begin
      sx = sa; ex = (ea == 8'd0) ? 8'd1 : ea; mx = {ea != 8'd0, a_i[22:0]};
      sy = sb; ey = (eb == 8'd0) ? 8'd1 : eb; my = {eb != 8'd0, b_i[22:0]};
    end

    // align: everything shifted below the round bit collapses into sticky
    d    = ex - ey;
    sh_y = {my, 26'd0} >> d;
    if (d >= 8'd50) al_y = {26'd0, |my};
    else            al_y = {sh_y[49:24], |sh_y[23:0]};

    if (sx == sy) s = {1'b0, mx, 3'b000} + {1'b0, al_y};
    else          s = {1'b0, mx, 3'b000} - {1'b0, al_y};

    lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (s[i]) lz = 5'(26 - i);
    end

    nsh = 8'd0;
    if (s[27]) begin
      n  = {s[26:2], s[1] | s[0]} | {s[27], 26'd0};
      n  = {s[27:2], s[1] | s[0]};
      en = {1'b0, ex} + 9'd1;
    end else begin
      // stop left shifts at exponent 1: the result is then subnormal
      nsh = ({3'd0, lz} < (ex - 8'd1)) ? {3'd0, lz} : (ex - 8'd1);
      n   = s[26:0] << nsh;
      en  = {1'b0, ex} - {1'b0, nsh};
    end

    rnd = n[2] & (n[1] | n[0] | n[3]);
    if (en >= 9'd255) pk = {8'hFF, 23'd0};
    else              pk = {(n[26] ? en[7:0] : 8'd0), n[25:3]} + {30'd0, rnd};

    if (s == 28'd0) y_o = {sa & sb, 31'd0};
    else            y_o = {sx, pk};

    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) y_o = FP_QNAN;
    else if (a_inf)                                       y_o = {sa, 8'hFF, 23'd0};
    else if (b_inf)                                       y_o = {sb, 8'hFF, 23'd0};
  end

endmodule

// File: rtl/fadd32_accum.sv
// fadd32_accum: streaming binary32 accumulator around one fadd32 core.
// A job (start, len) folds len operands into acc, each added or subtracted
// per in_mode, then presents acc on the result stream until consumed.
//   clk      : rising-edge clock
//   rst_n    : synchronous active-low reset; abandons any job
//   bus      : fadd32_accum_if.slave (job, operand and result streams,
//              busy, dbg_state)
// Optional build macro FADD32_ACCUM_OPREG_EN: operands are registered on
// accept and added the following cycle (result latency 2 from the last
// accept instead of 1); operand throughput stays one per cycle.
module fadd32_accum
  import fadd32_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  fadd32_accum_if.slave bus
);

  state_t           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic [31:0]      fa_b;
  logic             fa_mode;
  logic [31:0]      sum;

`ifdef FADD32_ACCUM_OPREG_EN
  logic [31:0] op_q, op_d;
  logic        op_mode_q, op_mode_d;
  logic        op_valid_q, op_valid_d;

  assign fa_b    = op_q;
  assign fa_mode = op_mode_q;
  // cnt reaches 0 after the last accept; the add for it is still pending
  assign bus.in_ready = rst_n && (state_q == ACCUM) && (cnt_q != '0);
`else
  assign fa_b    = bus.in_data;
  assign fa_mode = bus.in_mode;
  assign bus.in_ready = rst_n && (state_q == ACCUM);
`endif

  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = rst_n && (state_q == DONE);
  assign bus.busy      = rst_n && ((state_q == ACCUM) || (state_q == DONE));
  assign bus.out_data  = rst_n ? acc_q : FP_POS_ZERO;
  assign bus.dbg_state = state_q;

  fadd32 u_fadd32 (
    .a_i    (acc_q),
    .b_i    (fa_b),
    .mode_i (fa_mode),
    .y_o    (sum)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
`ifdef FADD32_ACCUM_OPREG_EN
    op_d       = op_q;
    op_mode_d  = op_mode_q;
    op_valid_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d = FP_POS_ZERO;
          if (bus.len != '0) begin
            cnt_d   = bus.len;
            state_d = ACCUM;
          end else begin
            state_d = DONE;
          end
        end
      end
      ACCUM: begin
`ifdef FADD32_ACCUM_OPREG_EN
        op_valid_d = accept;
        if (accept) begin
          op_d      = bus.in_data;
          op_mode_d = bus.in_mode;
          cnt_d     = cnt_q - LEN_W'(1);
        end
        if (op_valid_q) begin
          acc_d = sum;
          if (cnt_q == '0) state_d = DONE;
        end
`else
        if (accept) begin
          acc_d = sum;
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = DONE;
        end
`endif
      end
      DONE: begin
        // start is not looked at here, so a job cannot begin in this cycle
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= FP_POS_ZERO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FADD32_ACCUM_OPREG_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q       <= FP_POS_ZERO;
      op_mode_q  <= MODE_ADD;
      op_valid_q <= 1'b0;
    end else begin
      op_q       <= op_d;
      op_mode_q  <= op_mode_d;
      op_valid_q <= op_valid_d;
    end
  end
`endif

endmodule

// File: tb/tb_fadd32_accum.sv
module tb_fadd32_accum;
  import fadd32_pkg::*;

  localparam int LEN_W = 8;
`ifdef FADD32_ACCUM_OPREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fadd32_accum_if #(.LEN_W(LEN_W)) bus();

  fadd32_accum #(.LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic ready_fixed = 1'b1;
  logic rand_ready  = 1'b0;
  logic rr          = 1'b1;
  always @(posedge clk) rr <= 1'($urandom_range(0, 1));
  assign bus.out_ready = rand_ready ? rr : ready_fixed;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_acc;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic fail_line(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ---------------- reference model ----------------
  // Exact arithmetic: every binary32 is an integer multiple of 2^-149, so
  // values are held as signed integers in that unit and rounded once.
  function automatic logic signed [299:0] to_fix(input logic [31:0] x);
    logic signed [299:0] v;
    int e;
    e = (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
    v = '0;
    v[23:0] = {x[30:23] != 8'd0, x[22:0]};
    v = v << (e - 1);
    if (x[31]) v = -v;
    return v;
  endfunction

  function automatic logic [31:0] from_fix(input logic signed [299:0] v, input logic zs);
    logic [299:0] mag, keep, rem, half;
    logic [31:0]  pk;
    logic         neg;
    int           p, sh, eb;
    if (v == 0) return {zs, 31'd0};
    neg = (v < 0);
    mag = neg ? -v : v;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    if (p <= 23) return {neg, mag[30:0]};
    sh   = p - 23;
    keep = mag >> sh;
    rem  = mag - (keep << sh);
    half = 300'd1 << (sh - 1);
    eb   = sh + 1;
    if (eb >= 255) return {neg, 8'hFF, 23'd0};
    pk = {1'b0, eb[7:0], keep[22:0]};
    if (rem > half || (rem == half && keep[0])) pk = pk + 32'd1;
    return {neg, pk[30:0]};
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic m);
    logic [31:0] nb;
    nb = {b[31] ^ m, b[30:0]};
    return from_fix(to_fix(a) + to_fix(nb), a[31] & nb[31]);
  endfunction

  function automatic logic [31:0] rand_op();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return {1'($urandom_range(0, 1)), 31'd0};
    if (k == 1) return {1'($urandom_range(0, 1)), 8'd0, 23'($urandom)};
    return {1'($urandom_range(0, 1)), 8'($urandom_range(115, 135)), 23'($urandom)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int l);
    bus.start = 1'b1;
    bus.len   = LEN_W'(l);
    tick();
    bus.start = 1'b0;
    model_acc = FP_POS_ZERO;
  endtask

  task automatic feed(input logic [31:0] d, input logic m);
    int   k;
    logic took;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_mode  = m;
    k    = 0;
    took = 1'b0;
    while (!took && k < 200) begin
      @(negedge clk);
      took = bus.in_ready;
      tick();
      k++;
    end
    bus.in_valid = 1'b0;
    if (!took) fail_line("feed accept");
    model_acc = ref_add(model_acc, d, m);
  endtask

  task automatic wait_out(input string name);
    for (int i = 1; i < LAT; i++) begin
      @(negedge clk);
      check({name, " out_valid early"}, 32'(bus.out_valid), 32'd0);
      tick();
    end
    @(negedge clk);
    check({name, " out_valid"}, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 500) begin
      tick();
      k++;
    end
    if (k == 500) fail_line({name, " result drain"});
    else if (k == 0) tick();
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL result: got %08h expected none", bus.out_data);
      end else begin
        check("result", bus.out_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time bound expired");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    logic        m;
    int          l;

    bus.start    = 1'b0;
    bus.len      = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_mode  = MODE_ADD;
    model_acc    = FP_POS_ZERO;

    // reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst in_ready", 32'(bus.in_ready), 32'd0);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst out_data", bus.out_data, 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("post-rst state", 32'(bus.dbg_state), 32'(IDLE));
    check("post-rst out_data", bus.out_data, 32'd0);
    tick();

    // basic sum 1+2+3
    exp_q.push_back(32'h40C0_0000);
    start_job(3);
    @(negedge clk);
    check("basic busy", 32'(bus.busy), 32'd1);
    tick();
    feed(32'h3F80_0000, MODE_ADD);
    feed(32'h4000_0000, MODE_ADD);
    feed(32'h4040_0000, MODE_ADD);
    wait_out("basic");
    wait_idle("basic");

    // subtract with stalls; a start pulse during ACCUM is ignored
    exp_q.push_back(32'hBF00_0000);
    start_job(2);
    feed(32'h3F80_0000, MODE_SUB);
    bus.start = 1'b1;
    bus.len   = LEN_W'(7);
    repeat (2) begin
      tick();
      @(negedge clk);
      check("stall acc hold", bus.out_data, 32'hBF80_0000);
      check("stall in_ready", 32'(bus.in_ready), 32'd1);
    end
    bus.start = 1'b0;
    tick();
    feed(32'h3F00_0000, MODE_ADD);
    wait_out("sub");
    wait_idle("sub");

    // empty job
    exp_q.push_back(32'h0000_0000);
    start_job(0);
    @(negedge clk);
    check("empty in_ready", 32'(bus.in_ready), 32'd0);
    check("empty out_valid", 32'(bus.out_valid), 32'd1);
    wait_idle("empty");

    // backpressure, then start coinciding with the result handshake
    ready_fixed = 1'b0;
    exp_q.push_back(32'h4000_0000);
    start_job(1);
    feed(32'h4000_0000, MODE_ADD);
    for (int i = 1; i < LAT; i++) tick();
    repeat (5) begin
      @(negedge clk);
      check("bp out_valid", 32'(bus.out_valid), 32'd1);
      check("bp out_data", bus.out_data, 32'h4000_0000);
      tick();
    end
    ready_fixed = 1'b1;
    bus.start   = 1'b1;
    bus.len     = LEN_W'(5);
    tick();
    bus.start = 1'b0;
    @(negedge clk);
    check("start-in-done busy", 32'(bus.busy), 32'd0);
    check("start-in-done out_valid", 32'(bus.out_valid), 32'd0);
    check("start-in-done state", 32'(bus.dbg_state), 32'(IDLE));
    tick();

    // reset mid-job
    start_job(4);
    feed(32'h4000_0000, MODE_ADD);
    feed(32'h4040_0000, MODE_ADD);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst in_ready", 32'(bus.in_ready), 32'd0);
    check("midrst out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst state", 32'(bus.dbg_state), 32'(IDLE));
    check("midrst in_ready after", 32'(bus.in_ready), 32'd0);
    check("midrst out_valid after", 32'(bus.out_valid), 32'd0);
    check("midrst acc", bus.out_data, 32'd0);
    tick();
    exp_q.push_back(32'h3F80_0000);
    start_job(1);
    feed(32'h3F80_0000, MODE_ADD);
    wait_out("post-rst job");
    wait_idle("post-rst job");

    // randomized jobs against the exact-arithmetic model
    rand_ready = 1'b1;
    for (int j = 0; j < 30; j++) begin
      l = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 12));
      start_job(l);
      if (l == 0) exp_q.push_back(FP_POS_ZERO);
      for (int e = 0; e < l; e++) begin
        if ($urandom_range(0, 7) == 0) begin
          d = model_acc;
          m = MODE_SUB;
        end else begin
          d = rand_op();
          m = 1'($urandom_range(0, 1));
        end
        repeat ($urandom_range(0, 2)) tick();
        feed(d, m);
      end
      if (l != 0) exp_q.push_back(model_acc);
      wait_idle("random");
    end
    rand_ready = 1'b0;
    repeat (3) tick();
    check("scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
